// File: rtl/fetch_queue_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary: datapath width,
// reset PC, the nop encoding and the {PC, instruction} entry layout.
package fetch_queue_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // One buffered fetch: program counter plus the instruction word at it.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue.sv
// Decoupling FIFO between the IFU and decode. Holds {PC, instruction} pairs,
// presents the head first-word-fall-through, back-pressures the IFU when full
// and drops everything on a flush. Handshake outputs come only from registered
// occupancy, so there is no F_valid->F_ready or D_ready->D_valid path.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      F_PC,
    input  logic [31:0]      F_instruct,
    input  logic             F_valid,
    output logic             F_ready,
    output logic [31:0]      D_PC,
    output logic [31:0]      D_instruct,
    output logic             D_valid,
    input  logic             D_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    fq_entry_t        entries [DEPTH];
    fq_entry_t        head;
    fq_entry_t        wr_entry;
    logic             push;
    logic             pop;
    logic             wr_en;

    // Handshakes are derived purely from the registered count.
    assign F_ready  = (count_q != CNT_W'(DEPTH));
    assign D_valid  = (count_q != '0);
    assign push     = F_valid && F_ready;
    assign pop      = D_valid && D_ready;
    assign wr_en    = push && !flush && !reset;
    assign wr_entry = '{pc: F_PC, instr: F_instruct};

    // Per-entry storage: an entry only loads when it is the write target.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            fq_entry_t entry_q;

            // Capture the incoming fetch into this slot when wptr points here.
            always_ff @(posedge clk) begin
                if (wr_en && (wptr_q == PTR_W'(gi))) begin
                    entry_q <= wr_entry;
                end
            end

            assign entries[gi] = entry_q;
        end
    endgenerate

    // Head read; an empty queue shows a nop at PC 0 so decode sees a bubble.
    assign head       = entries[rptr_q];
    assign D_PC       = D_valid ? head.pc    : '0;
    assign D_instruct = D_valid ? head.instr : NOP_INSTR;
    assign count      = count_q;

    // Next-state pointers and occupancy; flush overrides any push/pop.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

endmodule : fetch_queue
